fp_norm_lzc_stage: RTL and testbench

Pipelined leading-zero-count and normalization-control stage in the FP add/sub datapath. It sits directly upstream of the 28-bit left normalization shifter. It takes the raw 28-bit mantissa sum with its exponent and sign, then produces the shift amount, the adjusted exponent and the zero/overflow flags. The payload is returned aligned with these results so the shifter consumes it unmodified. Two register stages are joined by a valid/ready handshake.

---
 rtl/fp_norm_lzc_stage.sv | 143 ++++++++++++++
 tb/tb_fp_norm_lzc_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_lzc_stage.sv
// Two-stage leading-zero count and normalization control for the FP add/sub path.
// S1 registers the payload with per-nibble zero flags and local counts; S2 resolves shift, exponent and flags.
module fp_norm_lzc_stage #(
    parameter int DATA_W  = 28,
    parameter int EXP_W   = 8,
    parameter int SHIFT_W = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [DATA_W-1:0]  i_data,
    input  logic [EXP_W-1:0]   i_exp,
    input  logic               i_sign,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [DATA_W-1:0]  o_data,
    output logic [SHIFT_W-1:0] o_shift_number,
    output logic [EXP_W-1:0]   o_exp,
    output logic               o_sign,
    output logic               o_zero,
    output logic               o_overflow
);

    localparam int NIB_N  = (DATA_W + 3) / 4;
    localparam int PAD_W  = NIB_N * 4;
    localparam int CALC_W = EXP_W + 1;

    // Leading zeros inside one nibble; the value for an all-zero nibble is never used.
    function automatic logic [1:0] nib_lz(input logic [3:0] n);
        if (n[3])      return 2'd0;
        else if (n[2]) return 2'd1;
        else if (n[1]) return 2'd2;
        else           return 2'd3;
    endfunction

    logic                    s1_valid;
    logic [DATA_W-1:0]       s1_data;
    logic [EXP_W-1:0]        s1_exp;
    logic                    s1_sign;
    logic [NIB_N-1:0]        s1_nib_zero;
    logic [NIB_N-1:0][1:0]   s1_nib_lz;

    logic [PAD_W-1:0]        padded;
    logic [NIB_N-1:0]        nib_zero;
    logic [NIB_N-1:0][1:0]   nib_lz_v;

    logic                    s2_load;
    logic [CALC_W-1:0]       lzc;
    logic [CALC_W-1:0]       e_ext;
    logic [CALC_W-1:0]       e_inc;
    logic [SHIFT_W-1:0]      shift_nx;
    logic [EXP_W-1:0]        exp_nx;
    logic                    zero_nx;
    logic                    ovf_nx;

    assign s2_load = !o_valid || i_ready;
    assign o_ready = !s1_valid || s2_load;

    // Nibble 0 is the most significant; any padding sits below the LSB so it never adds leading zeros.
    // NOTE: every signal driven from always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        padded   = PAD_W'(i_data) << (PAD_W - DATA_W);
        nib_zero = '0;
        nib_lz_v = '0;
        for (int k = 0; k < NIB_N; k++) begin
            nib_zero[k] = (padded[PAD_W-1-4*k -: 4] == 4'd0);
            nib_lz_v[k] = nib_lz(padded[PAD_W-1-4*k -: 4]);
        end
    end

    // The highest-order non-zero nibble wins, so scan from the bottom and let later hits overwrite.
    always_comb begin
        lzc = '0;
        for (int k = NIB_N - 1; k >= 0; k--) begin
            if (!s1_nib_zero[k])
                lzc = CALC_W'(4 * k) + CALC_W'(s1_nib_lz[k]);
        end
        e_ext = (s1_exp == '0) ? CALC_W'(1) : {1'b0, s1_exp};
        e_inc = e_ext + CALC_W'(1);

        shift_nx = '0;
        exp_nx   = '0;
        zero_nx  = 1'b0;
        ovf_nx   = 1'b0;
        if (&s1_nib_zero) begin
            zero_nx = 1'b1;
        end else if (lzc == '0) begin
            if (e_inc >= CALC_W'((1 << EXP_W) - 1)) begin
                ovf_nx = 1'b1;
                exp_nx = '1;
            end else begin
                exp_nx = e_inc[EXP_W-1:0];
            end
        end else if (lzc <= e_ext) begin
            shift_nx = lzc[SHIFT_W-1:0];
            exp_nx   = EXP_W'(e_inc - lzc);
        end else begin
            // Underflow: shift only as far as the exponent allows and land on a denormal.
            shift_nx = e_ext[SHIFT_W-1:0];
        end
    end

    // NOTE: state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid       <= 1'b0;
            s1_data        <= '0;
            s1_exp         <= '0;
            s1_sign        <= 1'b0;
            s1_nib_zero    <= '0;
            s1_nib_lz      <= '0;
            o_valid        <= 1'b0;
            o_data         <= '0;
            o_shift_number <= '0;
            o_exp          <= '0;
            o_sign         <= 1'b0;
            o_zero         <= 1'b0;
            o_overflow     <= 1'b0;
        end else begin
            if (o_ready)
                s1_valid <= i_valid;
            if (i_valid && o_ready) begin
                s1_data     <= i_data;
                s1_exp      <= i_exp;
                s1_sign     <= i_sign;
                s1_nib_zero <= nib_zero;
                s1_nib_lz   <= nib_lz_v;
            end
            if (s2_load)
                o_valid <= s1_valid;
            if (s2_load && s1_valid) begin
                o_data         <= s1_data;
                o_shift_number <= shift_nx;
                o_exp          <= exp_nx;
                o_sign         <= s1_sign;
                o_zero         <= zero_nx;
                o_overflow     <= ovf_nx;
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_lzc_stage.sv
// Scoreboard bench for fp_norm_lzc_stage: directed plan cases, back-pressure, mid-stream reset, random traffic.
// Inputs change 1 time unit after the rising edge; all sampling happens on the falling edge.
module tb_fp_norm_lzc_stage;

    localparam int DATA_W  = 28;
    localparam int EXP_W   = 8;
    localparam int SHIFT_W = 5;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [SHIFT_W-1:0] shift;
        logic [EXP_W-1:0]   exp;
        logic               sign;
        logic               zero;
        logic               ovf;
    } result_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic [EXP_W-1:0]   in_exp;
    logic               in_sign;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [SHIFT_W-1:0] out_shift;
    logic [EXP_W-1:0]   out_exp;
    logic               out_sign;
    logic               out_zero;
    logic               out_ovf;

    int checks = 0;
    int passes = 0;
    int popped = 0;
    bit saw_ready_low = 0;
    bit rand_bp = 0;
    result_t exp_q[$];

    fp_norm_lzc_stage #(.DATA_W(DATA_W), .EXP_W(EXP_W), .SHIFT_W(SHIFT_W)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_valid(in_valid), .o_ready(in_ready),
        .i_data(in_data), .i_exp(in_exp), .i_sign(in_sign),
        .o_valid(out_valid), .i_ready(out_ready),
        .o_data(out_data), .o_shift_number(out_shift), .o_exp(out_exp),
        .o_sign(out_sign), .o_zero(out_zero), .o_overflow(out_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Reference: count leading zeros bit by bit with integers, then apply the normalization rules.
    function automatic result_t model(input logic [DATA_W-1:0] d, input logic [EXP_W-1:0] ex,
                                      input logic s);
        result_t r;
        int e;
        int lz;
        r = '0;
        r.data = d;
        r.sign = s;
        e = (ex == 0) ? 1 : int'(ex);
        if (d == 0) begin
            r.zero = 1'b1;
            return r;
        end
        lz = 0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (d[i]) begin
                lz = DATA_W - 1 - i;
                break;
            end
        end
        if (lz == 0) begin
            if (e + 1 >= (1 << EXP_W) - 1) begin
                r.ovf = 1'b1;
                r.exp = '1;
            end else begin
                r.exp = EXP_W'(e + 1);
            end
        end else if (lz <= e) begin
            r.shift = SHIFT_W'(lz);
            r.exp   = EXP_W'(e + 1 - lz);
        end else begin
            r.shift = SHIFT_W'(e);
        end
        return r;
    endfunction

    function automatic result_t dut_out();
        result_t r;
        r.data = out_data; r.shift = out_shift; r.exp = out_exp;
        r.sign = out_sign; r.zero = out_zero; r.ovf = out_ovf;
        return r;
    endfunction

    // Scoreboard: push on input handshakes, pop and compare on output handshakes, watch stalls.
    result_t held;
    bit      have_hold = 0;
    always @(negedge clk) begin
        result_t cur;
        result_t req;
        if (rst) begin
            exp_q.delete();
            have_hold = 0;
        end else begin
            if (!in_ready) saw_ready_low = 1;
            if (in_valid && in_ready) exp_q.push_back(model(in_data, in_exp, in_sign));
            if (out_valid) begin
                cur = dut_out();
                if (have_hold) check("stall_hold", 64'(cur), 64'(held));
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 64'(cur), 64'(0));
                    end else begin
                        req = exp_q.pop_front();
                        popped++;
                        check("scoreboard", 64'(cur), 64'(req));
                    end
                    have_hold = 0;
                end else begin
                    held = cur;
                    have_hold = 1;
                end
            end else begin
                if (have_hold) check("stall_valid_drop", 64'(out_valid), 64'(1));
                have_hold = 0;
            end
        end
    end

    // Called 1 unit after a rising edge; returns 1 unit after the edge that accepted the item.
    task automatic send(input logic [DATA_W-1:0] d, input logic [EXP_W-1:0] ex, input logic s);
        bit accepted = 0;
        int waited = 0;
        in_valid = 1'b1; in_data = d; in_exp = ex; in_sign = s;
        do begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk); #1;
            waited++;
        end while (!accepted && waited < 200);
        if (!accepted) check("send_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic directed(input string name, input logic [DATA_W-1:0] d, input logic [EXP_W-1:0] ex,
                            input logic [SHIFT_W-1:0] shift, input logic [EXP_W-1:0] e_out,
                            input logic zero, input logic ovf);
        result_t req;
        @(posedge clk); #1;
        send(d, ex, 1'b1);
        @(negedge clk);
        check({name, "_not_early"}, 64'(out_valid), 64'(0));
        @(negedge clk);
        check({name, "_valid"}, 64'(out_valid), 64'(1));
        req = '{data: d, shift: shift, exp: e_out, sign: 1'b1, zero: zero, ovf: ovf};
        check(name, 64'(dut_out()), 64'(req));
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_outputs"},
              {20'(0), out_valid, out_data, out_shift, out_exp, out_sign, out_zero, out_ovf}, 64'(0));
        check({name, "_ready"}, 64'(in_ready), 64'(1));
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'(0));
    endtask

    // Randomised back-pressure during the random phase only.
    always @(posedge clk) begin
        #1;
        if (rand_bp) out_ready = ($urandom_range(0, 9) < 7);
    end

    function automatic logic [DATA_W-1:0] rand_data();
        int lz;
        logic [DATA_W-1:0] v;
        lz = $urandom_range(0, DATA_W);
        if (lz == DATA_W) return '0;
        v = DATA_W'($urandom) | {1'b1, {(DATA_W-1){1'b0}}};
        return v >> lz;
    endfunction

    function automatic logic [EXP_W-1:0] rand_exp();
        case ($urandom_range(0, 5))
            0: return 8'd0;
            1: return 8'd1;
            2: return 8'd254;
            3: return 8'd255;
            4: return EXP_W'($urandom_range(0, 30));
            default: return EXP_W'($urandom);
        endcase
    endfunction

    initial begin
        int base;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_exp = '0; in_sign = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        directed("carry",       28'h8000000, 8'd127, 5'd0,  8'd128, 1'b0, 1'b0);
        directed("hidden",      28'h4000000, 8'd127, 5'd1,  8'd127, 1'b0, 1'b0);
        directed("lsb_only",    28'h0000001, 8'd127, 5'd27, 8'd101, 1'b0, 1'b0);
        directed("denormal",    28'h0000100, 8'd5,   5'd5,  8'd0,   1'b0, 1'b0);
        directed("zero",        28'h0000000, 8'd90,  5'd0,  8'd0,   1'b1, 1'b0);
        directed("overflow",    28'h8000000, 8'd254, 5'd0,  8'hFF, 1'b0, 1'b1);
        directed("no_overflow", 28'h8000000, 8'd253, 5'd0,  8'd254, 1'b0, 1'b0);
        directed("exp_zero",    28'h4000000, 8'd0,   5'd1,  8'd1,   1'b0, 1'b0);
        directed("lz_eq_exp",   28'h0100000, 8'd7,   5'd7,  8'd1,   1'b0, 1'b0);

        // Back-to-back stream of 5 with a 3-cycle downstream stall in the middle.
        @(posedge clk); #1;
        saw_ready_low = 0;
        base = popped;
        fork
            for (int i = 0; i < 5; i++) send(rand_data(), EXP_W'($urandom_range(1, 200)), 1'($urandom));
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("backpressure");
        check("bp_ready_low", 64'(saw_ready_low), 64'(1));
        check("bp_count", 64'(popped - base), 64'(5));

        // Fill both stages, then reset for one cycle.
        out_ready = 1'b0;
        send(28'h0123456, 8'd40, 1'b0);
        send(28'h0ABCDEF, 8'd41, 1'b1);
        @(negedge clk);
        check("full_ready_low", 64'(in_ready), 64'(0));
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state("mid_reset");
        out_ready = 1'b1;
        directed("after_reset", 28'h0008000, 8'd100, 5'd12, 8'd89, 1'b0, 1'b0);
        drain("after_reset");

        // Random traffic with random gaps and random back-pressure.
        base = popped;
        rand_bp = 1;
        for (int i = 0; i < 300; i++) begin
            send(rand_data(), rand_exp(), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rand_bp = 0;
        out_ready = 1'b1;
        drain("random");
        check("random_count", 64'(popped - base), 64'(300));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
